// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_e   : controller states (IDLE/RUN/DONE)
//   ndig      : number of digits per operand (WIDTH/DIGIT)
//   cnt_width : digit counter width, $clog2(NDIG) with a 1-bit floor
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    // A zero DIGIT is rejected at elaboration; avoid dividing by it here.
    return (digit == 0) ? 1 : width / digit;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned digit);
    int unsigned n;
    n = ndig(width, digit);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for digit_serial_adder.
//   master : operand producer / result consumer (drives in_valid, a, b, c_in,
//            sub, out_ready)
//   slave  : the adder (drives in_ready, out_valid, sum, carry_out, overflow)
interface digit_serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );

endinterface

// File: rtl/digit_serial_adder_digit.sv
// Combinational DIGIT-bit ripple adder built from 1-bit full-adder cells.
//   a_i, b_i : DIGIT-bit addend digits
//   c_i      : carry into bit 0
//   s_o      : DIGIT-bit sum digit
//   c_o      : carry out of the top bit
//   c_msb_o  : carry into the top bit (overflow detection)
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o     = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor. Consumes WIDTH-bit operands DIGIT bits per
// clock, LSB digit first, and presents the result through a valid/ready pair.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of digit_serial_adder_if (operands in, result out)
// Mode: sub=0 computes A+B+c_in, sub=1 computes A-B-c_in (as A+~B+~c_in).
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_serial_adder_if.slave  bus
);

  localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
  localparam int unsigned CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [DIGIT-1:0] dig_s;
  logic             dig_c;
  logic             dig_cm;
  logic [WIDTH-1:0] acc_d;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .c_i     (carry_q),
    .s_o     (dig_s),
    .c_o     (dig_c),
    .c_msb_o (dig_cm)
  );

  // The A register doubles as the sum shift register: each digit consumed from
  // the bottom frees room for the result digit at the top, so after NDIG shifts
  // it holds the full sum. The visible sum is copied only on the final digit so
  // the output stays still while the operation is in flight.
  assign acc_d = WIDTH'({dig_s, a_q} >> DIGIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.a;
            b_q        <= bus.sub ? ~bus.b : bus.b;
            carry_q    <= bus.c_in ^ bus.sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= acc_d;
          b_q     <= b_q >> DIGIT;
          carry_q <= dig_c;
          if (cnt_q == LAST) begin
            sum_q       <= acc_d;
            cout_q      <= dig_c;
            ovf_q       <= dig_cm ^ dig_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: WIDTH=8/DIGIT=2 instance with directed and
// randomized traffic against a queue-based arithmetic model, plus exhaustive
// WIDTH=4 sweeps for DIGIT in {1,2,4}.
module tb_digit_serial_adder;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned ND = W / D;

  logic clk = 1'b0;
  logic rst_n_m;
  logic rst_n_s;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   or_mode = 0;  // 0: out_ready=1, 1: out_ready=0, 2: random

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: {overflow, carry_out, sum[7:0]} from plain integer arithmetic.
  // Overflow is taken as "signed value of A + B' + cin leaves the w-bit range".
  function automatic logic [9:0] model(input int unsigned w, input int unsigned a,
                                       input int unsigned b, input bit cin, input bit sub);
    int unsigned mask, bb, c0, full;
    int half, ai, bi, s;
    bit ovf, cout;
    mask = (1 << w) - 1;
    bb   = sub ? (~b & mask) : (b & mask);
    c0   = (cin ^ sub) ? 1 : 0;
    full = (a & mask) + bb + c0;
    half = 1 << (w - 1);
    ai   = int'(a & mask);
    bi   = int'(bb);
    if (ai >= half) ai = ai - 2 * half;
    if (bi >= half) bi = bi - 2 * half;
    s    = ai + bi + int'(c0);
    ovf  = (s < -half) || (s >= half);
    cout = ((full >> w) & 1) != 0;
    return {ovf, cout, 8'(full & mask)};
  endfunction

  // ---------------- main instance ----------------
  digit_serial_adder_if #(.WIDTH(W)) m_if ();

  digit_serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk   (clk),
    .rst_n (rst_n_m),
    .bus   (m_if.slave)
  );

  logic [9:0] exp_q[$];
  int         acc_q[$];
  bit         prev_ov = 1'b0;

  // Compare process: every negedge, check whatever the DUT presents.
  always @(negedge clk) begin
    if (!rst_n_m) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (m_if.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", m_if.out_valid, 0);
        end else begin
          chk("sum", m_if.sum, exp_q[0][7:0]);
          chk("carry_out", m_if.carry_out, exp_q[0][8]);
          chk("overflow", m_if.overflow, exp_q[0][9]);
          chk("in_ready_busy", m_if.in_ready, 0);
          if (!prev_ov) chk("latency", cyc - acc_q[0], ND);
          if (m_if.out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_ov = m_if.out_valid && !m_if.out_ready;
      if (m_if.in_valid && m_if.in_ready) begin
        exp_q.push_back(model(W, m_if.a, m_if.b, m_if.c_in, m_if.sub));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  // out_ready driver, applied 2 time units after each rising edge.
  initial begin
    m_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       m_if.out_ready = 1'b1;
        1:       m_if.out_ready = 1'b0;
        default: m_if.out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s);
    int n;
    m_if.a = a; m_if.b = b; m_if.c_in = ci; m_if.sub = s;
    m_if.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_if.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!m_if.in_ready) chk("send_timeout", m_if.in_ready, 1);
    @(posedge clk);
    #1 m_if.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    @(negedge clk);
    while (!m_if.out_valid && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic directed(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic s, input logic [7:0] es,
                          input logic ec, input logic eo);
    int lat;
    send(a, b, ci, s);
    wait_out(lat);
    chk({nm, "_latency"}, lat, ND);
    chk({nm, "_sum"}, m_if.sum, es);
    chk({nm, "_carry"}, m_if.carry_out, ec);
    chk({nm, "_ovf"}, m_if.overflow, eo);
    @(posedge clk);
    #1;
  endtask

  // ---------------- WIDTH=4 exhaustive sweeps ----------------
  for (genvar k = 0; k < 3; k++) begin : g_sweep
    localparam int unsigned SD = 1 << k;
    localparam int unsigned SN = 4 / SD;
    bit done = 1'b0;

    digit_serial_adder_if #(.WIDTH(4)) s_if ();

    digit_serial_adder #(.WIDTH(4), .DIGIT(SD)) u_dut (
      .clk   (clk),
      .rst_n (rst_n_s),
      .bus   (s_if.slave)
    );

    initial begin
      logic [9:0] cv;
      logic [9:0] e;
      int n;
      s_if.in_valid = 1'b0; s_if.a = '0; s_if.b = '0;
      s_if.c_in = 1'b0; s_if.sub = 1'b0; s_if.out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      for (int c = 0; c < 1024; c++) begin
        cv = 10'(c);
        s_if.a = cv[3:0]; s_if.b = cv[7:4]; s_if.c_in = cv[8]; s_if.sub = cv[9];
        s_if.in_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("sw%0d_in_ready", SD), s_if.in_ready, 1);
        @(posedge clk);
        #1 s_if.in_valid = 1'b0;
        e = model(4, cv[3:0], cv[7:4], cv[8], cv[9]);
        n = 0;
        @(negedge clk);
        while (!s_if.out_valid && n < 40) begin
          n++;
          @(negedge clk);
        end
        chk($sformatf("sw%0d_latency", SD), n, SN);
        chk($sformatf("sw%0d_sum", SD), s_if.sum, e[3:0]);
        chk($sformatf("sw%0d_carry", SD), s_if.carry_out, e[8]);
        chk($sformatf("sw%0d_ovf", SD), s_if.overflow, e[9]);
        @(posedge clk);
        #1;
      end
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n;
    m_if.in_valid = 1'b0; m_if.a = '0; m_if.b = '0; m_if.c_in = 1'b0; m_if.sub = 1'b0;
    rst_n_m = 1'b0;
    rst_n_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", m_if.in_ready, 1);
    chk("rst_out_valid", m_if.out_valid, 0);
    chk("rst_sum", m_if.sum, 0);
    chk("rst_carry", m_if.carry_out, 0);
    chk("rst_ovf", m_if.overflow, 0);
    rst_n_m = 1'b1;
    rst_n_s = 1'b1;
    @(posedge clk);
    #1;

    directed("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    directed("sub1020", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    directed("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    directed("addff01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);

    // Back-pressure: 0x7E - 0x05 - 1 = 0x78, no borrow, no overflow.
    or_mode = 1;
    send(8'h7E, 8'h05, 1'b1, 1'b1);
    wait_out(lat);
    chk("bp_latency", lat, ND);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      m_if.in_valid = (i % 2) == 0;
      m_if.a = 8'($urandom); m_if.b = 8'($urandom);
      m_if.c_in = 1'($urandom); m_if.sub = 1'($urandom);
      @(negedge clk);
      chk("bp_hold_valid", m_if.out_valid, 1);
      chk("bp_hold_sum", m_if.sum, 8'h78);
      chk("bp_hold_carry", m_if.carry_out, 1);
      chk("bp_hold_ovf", m_if.overflow, 0);
      chk("bp_hold_in_ready", m_if.in_ready, 0);
      @(posedge clk);
      #1;
    end
    m_if.a = 8'h33; m_if.b = 8'h11; m_if.c_in = 1'b0; m_if.sub = 1'b0;
    m_if.in_valid = 1'b1;
    or_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", m_if.in_ready, 1);
    chk("bp_release_out_valid", m_if.out_valid, 0);
    @(posedge clk);
    #1 m_if.in_valid = 1'b0;
    wait_out(lat);
    chk("bp_next_latency", lat, ND);
    chk("bp_next_sum", m_if.sum, 8'h44);
    @(posedge clk);
    #1;

    // Reset two digits into an operation.
    send(8'h21, 8'h43, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n_m = 1'b0;
    #1;
    chk("midrst_in_ready", m_if.in_ready, 1);
    chk("midrst_out_valid", m_if.out_valid, 0);
    chk("midrst_sum", m_if.sum, 0);
    chk("midrst_carry", m_if.carry_out, 0);
    chk("midrst_ovf", m_if.overflow, 0);
    @(posedge clk);
    #1 rst_n_m = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    directed("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

    // Randomized traffic with random gaps and random back-pressure.
    or_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    or_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);

    n = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && n < 40000) begin
      @(posedge clk);
      n++;
    end
    chk("sweep_complete", {g_sweep[2].done, g_sweep[1].done, g_sweep[0].done}, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
